// File: rtl/fx_regbank_if.sv
// rtl/fx_regbank_if.sv - fx byte bus bundle between a bus master and fx_regbank
interface fx_regbank_if;
   logic        fx_wr;
   logic [21:0] fx_waddr;
   logic [7:0]  fx_data;
   logic        fx_rd;
   logic [21:0] fx_raddr;
   logic [7:0]  fx_q;

   modport master (
      output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      input  fx_q
   );

   modport slave (
      input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      output fx_q
   );
endinterface

// File: rtl/fx_regbank.sv
// rtl/fx_regbank.sv - fx bus register bank with atomic config commits, status snapshots and sticky events
module fx_regbank #(
   parameter int                            CFG_NUM  = 4,
   parameter int                            STA_NUM  = 4,
   parameter int                            RW_BYTES = 2,
   parameter logic [15:0]                   CFG_BASE = 16'h0020,
   parameter logic [15:0]                   STA_BASE = 16'h0030,
   parameter logic [15:0]                   EVT_ADDR = 16'h0050,
   parameter logic [CFG_NUM*8*RW_BYTES-1:0] CFG_INIT = '0,
   parameter logic [7:0]                    VERSION  = 8'h02
) (
   input  logic                            clk_sys,
   input  logic                            rst_n,
   input  logic [5:0]                      dev_id,
   fx_regbank_if.slave                     fx,
   output logic [CFG_NUM*8*RW_BYTES-1:0]   cfg_q,
   output logic [CFG_NUM-1:0]              cfg_upd,
   input  logic [STA_NUM*8*RW_BYTES-1:0]   sta_d,
   input  logic [7:0]                      evt_in,
   output logic                            irq
);

   localparam int W     = 8 * RW_BYTES;
   // With single-byte registers there is nothing to stage; keep one dummy byte so the vector is legal.
   localparam int STG_N = (RW_BYTES > 1) ? RW_BYTES - 1 : 1;

   localparam int CFG_LO = int'(CFG_BASE);
   localparam int CFG_HI = CFG_LO + CFG_NUM * RW_BYTES;
   localparam int STA_LO = int'(STA_BASE);
   localparam int STA_HI = STA_LO + STA_NUM * RW_BYTES;
   localparam int EVT_LO = int'(EVT_ADDR);
   localparam int EVT_HI = EVT_LO + 2;

   function automatic bit overlap(input int a0, input int a1, input int b0, input int b1);
      return (a0 < b1) && (b0 < a1);
   endfunction

   // Half-open byte ranges: ID/version [0,2), config, status, event flags + mask.
   localparam bit MAP_BAD =
      overlap(0, 2, CFG_LO, CFG_HI)      || overlap(0, 2, STA_LO, STA_HI) ||
      overlap(0, 2, EVT_LO, EVT_HI)      || overlap(CFG_LO, CFG_HI, STA_LO, STA_HI) ||
      overlap(CFG_LO, CFG_HI, EVT_LO, EVT_HI) || overlap(STA_LO, STA_HI, EVT_LO, EVT_HI) ||
      (CFG_HI > 65536) || (STA_HI > 65536) || (EVT_HI > 65536);

   generate
      if (MAP_BAD) begin : g_map_check
         $error("fx_regbank: register address ranges overlap or exceed the 16-bit offset space");
      end
   endgenerate

   logic [CFG_NUM*W-1:0] cfg_d;
   logic [CFG_NUM-1:0]   cfg_upd_q, cfg_upd_d;
   logic [STG_N*8-1:0]   stg_q, stg_d;
   logic [STA_NUM*W-1:0] snap_q, snap_d;
   logic [7:0]           sticky_q, sticky_d;
   logic [7:0]           mask_q, mask_d;
   logic                 irq_q, irq_d;
   logic [7:0]           fx_q_q, fx_q_d;

   logic        wr_en, rd_en;
   logic [15:0] w_off, r_off;
   logic [W-1:0] commit_val;
   logic [7:0]  evt_clr;

   assign wr_en = fx.fx_wr & (fx.fx_waddr[21:16] == dev_id);
   assign rd_en = fx.fx_rd & (fx.fx_raddr[21:16] == dev_id);
   assign w_off = fx.fx_waddr[15:0];
   assign r_off = fx.fx_raddr[15:0];

   assign fx.fx_q = fx_q_q;
   assign cfg_upd = cfg_upd_q;
   assign irq     = irq_q;

   // Value a top-byte write commits: the written byte over whatever currently sits in staging.
   always_comb begin
      commit_val = '0;
      for (int bb = 0; bb < RW_BYTES - 1; bb++) begin
         commit_val[bb*8 +: 8] = stg_q[bb*8 +: 8];
      end
      commit_val[W-8 +: 8] = fx.fx_data;
   end

   // Write side: config staging/commit, event clear and mask update.
   always_comb begin
      cfg_d     = cfg_q;
      cfg_upd_d = '0;
      stg_d     = stg_q;
      mask_d    = mask_q;
      evt_clr   = 8'h00;
      if (wr_en) begin
         for (int i = 0; i < CFG_NUM; i++) begin
            for (int b = 0; b < RW_BYTES; b++) begin
               if (w_off == 16'(CFG_LO + i * RW_BYTES + b)) begin
                  if (b == RW_BYTES - 1) begin
                     cfg_d[i*W +: W] = commit_val;
                     cfg_upd_d[i]    = 1'b1;
                  end else begin
                     stg_d[b*8 +: 8] = fx.fx_data;
                  end
               end
            end
         end
         if (w_off == 16'(EVT_LO))     evt_clr = fx.fx_data;
         if (w_off == 16'(EVT_LO + 1)) mask_d  = fx.fx_data;
      end
      // New events win over a clear in the same cycle.
      sticky_d = (sticky_q & ~evt_clr) | evt_in;
      irq_d    = |(sticky_d & mask_d);
   end

   // Read side: byte mux from pre-write state; status byte 0 refreshes the snapshot.
   always_comb begin
      fx_q_d = 8'h00;
      snap_d = snap_q;
      if (rd_en) begin
         if (r_off == 16'h0000) fx_q_d = {2'b00, dev_id};
         if (r_off == 16'h0001) fx_q_d = VERSION;
         for (int i = 0; i < CFG_NUM; i++) begin
            for (int b = 0; b < RW_BYTES; b++) begin
               if (r_off == 16'(CFG_LO + i * RW_BYTES + b)) fx_q_d = cfg_q[i*W + b*8 +: 8];
            end
         end
         for (int j = 0; j < STA_NUM; j++) begin
            for (int b = 0; b < RW_BYTES; b++) begin
               if (r_off == 16'(STA_LO + j * RW_BYTES + b)) begin
                  if (b == 0) begin
                     snap_d[j*W +: W] = sta_d[j*W +: W];
                     fx_q_d           = sta_d[j*W +: 8];
                  end else begin
                     fx_q_d = snap_q[j*W + b*8 +: 8];
                  end
               end
            end
         end
         if (r_off == 16'(EVT_LO))     fx_q_d = sticky_q;
         if (r_off == 16'(EVT_LO + 1)) fx_q_d = mask_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q     <= CFG_INIT;
         cfg_upd_q <= '0;
         stg_q     <= '0;
         snap_q    <= '0;
         sticky_q  <= 8'h00;
         mask_q    <= 8'h00;
         irq_q     <= 1'b0;
         fx_q_q    <= 8'h00;
      end else begin
         cfg_q     <= cfg_d;
         cfg_upd_q <= cfg_upd_d;
         stg_q     <= stg_d;
         snap_q    <= snap_d;
         sticky_q  <= sticky_d;
         mask_q    <= mask_d;
         irq_q     <= irq_d;
         fx_q_q    <= fx_q_d;
      end
   end

endmodule

// File: tb/tb_fx_regbank.sv
// tb/tb_fx_regbank.sv - self-checking bench for fx_regbank with default parameters
module tb_fx_regbank;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic [5:0]  dev_id  = 6'h05;
   logic [63:0] cfg_q;
   logic [3:0]  cfg_upd;
   logic [63:0] sta_d   = 64'h0;
   logic [7:0]  evt_in  = 8'h00;
   logic        irq;

   fx_regbank_if fx ();

   fx_regbank dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .dev_id  (dev_id),
      .fx      (fx),
      .cfg_q   (cfg_q),
      .cfg_upd (cfg_upd),
      .sta_d   (sta_d),
      .evt_in  (evt_in),
      .irq     (irq)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: register map decoded by arithmetic on the offset.
   logic [15:0] m_cfg  [4];
   logic [15:0] m_snap [4];
   logic [7:0]  m_stg, m_sticky, m_mask, m_q;
   logic [3:0]  m_upd;
   logic        m_irq;

   task automatic model_step();
      int ro, wo, i, b;
      logic [7:0] rv, clr;
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_cfg[k]  = 16'h0;
            m_snap[k] = 16'h0;
         end
         m_stg = 0; m_sticky = 0; m_mask = 0; m_q = 0; m_upd = 0; m_irq = 0;
      end else begin
         rv = 8'h00;
         if (fx.fx_rd && fx.fx_raddr[21:16] == dev_id) begin
            ro = int'(fx.fx_raddr[15:0]);
            if (ro == 0) rv = {2'b00, dev_id};
            else if (ro == 1) rv = 8'h02;
            else if (ro >= 32 && ro < 40) rv = 8'(m_cfg[(ro-32)/2] >> (8*((ro-32)%2)));
            else if (ro >= 48 && ro < 56) begin
               i = (ro - 48) / 2;
               b = (ro - 48) % 2;
               if (b == 0) m_snap[i] = sta_d[i*16 +: 16];
               rv = 8'(m_snap[i] >> (8*b));
            end
            else if (ro == 80) rv = m_sticky;
            else if (ro == 81) rv = m_mask;
         end
         m_upd = 4'h0;
         clr   = 8'h00;
         if (fx.fx_wr && fx.fx_waddr[21:16] == dev_id) begin
            wo = int'(fx.fx_waddr[15:0]);
            if (wo >= 32 && wo < 40) begin
               i = (wo - 32) / 2;
               b = (wo - 32) % 2;
               if (b == 1) begin
                  m_cfg[i] = {fx.fx_data, m_stg};
                  m_upd[i] = 1'b1;
               end else begin
                  m_stg = fx.fx_data;
               end
            end
            else if (wo == 80) clr = fx.fx_data;
            else if (wo == 81) m_mask = fx.fx_data;
         end
         m_sticky = (m_sticky & ~clr) | evt_in;
         m_irq    = |(m_sticky & m_mask);
         m_q      = rv;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_sys or negedge rst_n);
         model_step();
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (chk_en) begin
            check("cyc_fx_q",    {56'h0, fx.fx_q}, {56'h0, m_q});
            check("cyc_cfg_q",   cfg_q, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
            check("cyc_cfg_upd", {60'h0, cfg_upd}, {60'h0, m_upd});
            check("cyc_irq",     {63'h0, irq}, {63'h0, m_irq});
         end
      end
   end

   function automatic logic [21:0] adr(input logic [15:0] o);
      return {6'h05, o};
   endfunction

   task automatic wr(input logic [21:0] a, input logic [7:0] d);
      fx.fx_wr = 1'b1; fx.fx_waddr = a; fx.fx_data = d;
      @(negedge clk_sys);
      fx.fx_wr = 1'b0;
   endtask

   task automatic rd(input logic [21:0] a, output logic [7:0] q);
      fx.fx_rd = 1'b1; fx.fx_raddr = a;
      @(negedge clk_sys);
      fx.fx_rd = 1'b0;
      q = fx.fx_q;
   endtask

   task automatic rw(input logic [21:0] a, input logic [7:0] d, output logic [7:0] q);
      fx.fx_wr = 1'b1; fx.fx_waddr = a; fx.fx_data = d;
      fx.fx_rd = 1'b1; fx.fx_raddr = a;
      @(negedge clk_sys);
      fx.fx_wr = 1'b0; fx.fx_rd = 1'b0;
      q = fx.fx_q;
   endtask

   logic [7:0] q;

   initial begin
      fx.fx_wr = 1'b0; fx.fx_waddr = '0; fx.fx_data = '0;
      fx.fx_rd = 1'b0; fx.fx_raddr = '0;
      repeat (3) @(negedge clk_sys);
      chk_en = 1'b1;
      check("rst_fx_q", {56'h0, fx.fx_q}, 64'h0);
      check("rst_cfg_q", cfg_q, 64'h0);
      check("rst_cfg_upd", {60'h0, cfg_upd}, 64'h0);
      check("rst_irq", {63'h0, irq}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk_sys);

      // Partial commit of cfg1.
      wr(adr(16'h0022), 8'h34);
      check("stage_no_commit", {48'h0, cfg_q[31:16]}, 64'h0);
      check("stage_no_upd", {60'h0, cfg_upd}, 64'h0);
      wr(adr(16'h0023), 8'h12);
      check("commit_cfg1", {48'h0, cfg_q[31:16]}, 64'h1234);
      check("commit_upd", {60'h0, cfg_upd}, 64'h2);
      @(negedge clk_sys);
      check("upd_one_cycle", {60'h0, cfg_upd}, 64'h0);
      rd(adr(16'h0022), q);
      check("rd_cfg1_b0", {56'h0, q}, 64'h34);
      rd(adr(16'h0023), q);
      check("rd_cfg1_b1", {56'h0, q}, 64'h12);
      @(negedge clk_sys);
      check("rd_idle_zero", {56'h0, fx.fx_q}, 64'h0);

      // Wrong device.
      wr({6'h06, 16'h0021}, 8'hAB);
      check("wrongdev_cfg0", {48'h0, cfg_q[15:0]}, 64'h0);
      check("wrongdev_upd", {60'h0, cfg_upd}, 64'h0);
      rd({6'h06, 16'h0022}, q);
      check("wrongdev_rd", {56'h0, q}, 64'h0);

      // Status snapshot.
      sta_d[15:0] = 16'hAA55;
      rd(adr(16'h0030), q);
      check("sta_b0", {56'h0, q}, 64'h55);
      sta_d[15:0] = 16'h1177;
      rd(adr(16'h0031), q);
      check("sta_b1_snap", {56'h0, q}, 64'hAA);

      // Sticky events and irq.
      evt_in = 8'h08;
      @(negedge clk_sys);
      evt_in = 8'h00;
      check("evt_nomask_irq", {63'h0, irq}, 64'h0);
      wr(adr(16'h0051), 8'h08);
      check("mask_irq_on", {63'h0, irq}, 64'h1);
      rd(adr(16'h0050), q);
      check("sticky_rd", {56'h0, q}, 64'h08);
      evt_in = 8'h08;
      wr(adr(16'h0050), 8'h08);
      evt_in = 8'h00;
      check("set_wins_irq", {63'h0, irq}, 64'h1);
      rd(adr(16'h0050), q);
      check("set_wins_flag", {56'h0, q}, 64'h08);
      wr(adr(16'h0050), 8'h08);
      check("clear_irq", {63'h0, irq}, 64'h0);
      rd(adr(16'h0050), q);
      check("clear_flag", {56'h0, q}, 64'h00);
      rd(adr(16'h0051), q);
      check("mask_rd", {56'h0, q}, 64'h08);

      // ID, version, unmapped; issued back to back.
      rd(adr(16'h0000), q);
      check("id_rd", {56'h0, q}, 64'h05);
      rd(adr(16'h0001), q);
      check("ver_rd", {56'h0, q}, 64'h02);
      rd(adr(16'h007F), q);
      check("unmapped_rd", {56'h0, q}, 64'h00);

      // Same-cycle read and write of a config top byte returns the old value.
      rw(adr(16'h0023), 8'h56, q);
      check("rw_old_value", {56'h0, q}, 64'h12);
      check("rw_commit_stale_stg", {48'h0, cfg_q[31:16]}, 64'h5634);

      // Consecutive commits give consecutive pulses.
      wr(adr(16'h0020), 8'h77);
      wr(adr(16'h0021), 8'hAA);
      check("b2b_upd0", {60'h0, cfg_upd}, 64'h1);
      wr(adr(16'h0023), 8'hBB);
      check("b2b_upd1", {60'h0, cfg_upd}, 64'h2);
      check("b2b_cfg", {32'h0, cfg_q[31:0]}, 64'hBB77AA77);

      // Reset between staged byte and commit.
      wr(adr(16'h0024), 8'h99);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cfg_q", cfg_q, 64'h0);
      check("midrst_fx_q", {56'h0, fx.fx_q}, 64'h0);
      check("midrst_upd", {60'h0, cfg_upd}, 64'h0);
      check("midrst_irq", {63'h0, irq}, 64'h0);
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      @(negedge clk_sys);
      wr(adr(16'h0025), 8'h00);
      check("midrst_cfg2", {48'h0, cfg_q[47:32]}, 64'h0);
      check("midrst_upd2", {60'h0, cfg_upd}, 64'h4);
      repeat (2) @(negedge clk_sys);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
